exe_muldiv_ctrl: RTL and testbench

- Sequencing controller for an iterative RV64M multiply/divide unit, placed beside the single-cycle execute ALU.
- The exe stage hands it MUL/DIV/REM operations over a valid/ready handshake.
- It runs a radix-2 shift-add (multiply) or restoring-subtract (divide) loop, then holds the result until the pipeline accepts it.
- `busy` lets the hazard logic stall the front end while a long operation is in flight.

---
 rtl/exe_muldiv_ctrl_pkg.sv | 38 +++
 rtl/exe_muldiv_dp.sv | 108 ++++++++++
 rtl/exe_muldiv_ctrl.sv | 131 +++++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_ctrl_pkg.sv
// Shared encodings, FSM state type and op-decoding helpers for the iterative
// RV64M multiply/divide unit.
package exe_muldiv_ctrl_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mduState_e;

    // rs1 is interpreted as signed (MUL low bits do not care either way)
    function automatic logic opSigned1(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // rs2 is interpreted as signed; MULHSU keeps rs2 unsigned
    function automatic logic opSigned2(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // result is a remainder rather than a quotient
    function automatic logic opIsRem(input logic [2:0] op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

endpackage

// File: rtl/exe_muldiv_dp.sv
// Datapath of the multiply/divide unit: operand magnitudes, the shared
// product/remainder shift register, one add-shift or restoring-subtract step
// per cycle, and the final sign fix-up / width selection of the result.
module exe_muldiv_dp
    import exe_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            is_mul_i,
    input  logic            is_word_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            neg1_i,
    input  logic            neg2_i,
    output logic [XLEN-1:0] result_o
);

    // prod_q holds {hi, lo}: for multiply hi accumulates and lo is the
    // multiplier being shifted out; for divide hi is the partial remainder
    // and lo is the dividend being shifted out while quotient bits shift in.
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              isMul_q, isWord_q, isRem_q, isHigh_q, negRes_q, negRem_q;

    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divTrial;
    logic              divFits;
    logic [XLEN-1:0]   divRem;

    logic [2*XLEN-1:0] mulMag, mulSigned;
    logic [XLEN-1:0]   mulSel, quo, rem, divSel, rawRes;

    assign mag1 = neg1_i ? -op1_i : op1_i;
    assign mag2 = neg2_i ? -op2_i : op2_i;

    assign mulSum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign divTrial = prod_q[2*XLEN-1:XLEN-1];
    assign divFits  = divTrial >= {1'b0, mcand_q};
    assign divRem   = divTrial[XLEN-1:0] - mcand_q;

    // Next value of the shift registers: load magnitudes on start, else one iteration per step
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        if (start_i) begin
            if (is_mul_i) begin
                mcand_d = mag1;
                prod_d  = {{XLEN{1'b0}}, mag2};
            end else begin
                mcand_d = mag2;
                // W divides pre-shift so the 32-bit dividend MSB sits at the top
                prod_d  = {{XLEN{1'b0}}, is_word_i ? {mag1[XLEN-33:0], 32'b0} : mag1};
            end
        end else if (step_i) begin
            if (isMul_q) begin
                prod_d = {mulSum, prod_q[XLEN-1:1]};
            end else if (divFits) begin
                prod_d = {divRem, prod_q[XLEN-2:0], 1'b1};
            end else begin
                prod_d = {divTrial[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Register the shift state and capture operation flags on start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            isMul_q  <= 1'b0;
            isWord_q <= 1'b0;
            isRem_q  <= 1'b0;
            isHigh_q <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            if (start_i) begin
                isMul_q  <= is_mul_i;
                isWord_q <= is_word_i;
                isRem_q  <= opIsRem(op_i);
                isHigh_q <= (op_i != MDU_MUL);
                negRes_q <= neg1_i ^ neg2_i;
                negRem_q <= neg1_i;
            end
        end
    end

    // A W product sits 32 bits high after 32 shifts; realign before negating the full 2N-bit value
    assign mulMag    = isWord_q ? {32'b0, prod_q[2*XLEN-1:32]} : prod_q;
    assign mulSigned = negRes_q ? -mulMag : mulMag;
    assign mulSel    = (isHigh_q && !isWord_q) ? mulSigned[2*XLEN-1:XLEN] : mulSigned[XLEN-1:0];

    assign quo    = prod_q[XLEN-1:0];
    assign rem    = prod_q[2*XLEN-1:XLEN];
    assign divSel = isRem_q ? (negRem_q ? -rem : rem) : (negRes_q ? -quo : quo);

    assign rawRes   = isMul_q ? mulSel : divSel;
    assign result_o = isWord_q ? {{(XLEN-32){rawRes[31]}}, rawRes[31:0]} : rawRes;

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// Sequencing controller for the iterative RV64M multiply/divide unit: request
// and response handshakes, iteration counter, divide special-case detection
// and the IDLE/CALC/DONE state machine.
module exe_muldiv_ctrl
    import exe_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            is_word_opt,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    mduState_e        state_q;
    logic [CNT_W-1:0] counter_q;
    logic             word_q;
    logic             respValid_q;
    logic [XLEN-1:0]  respData_q;

    logic             accept, sgn1, sgn2, neg1, neg2, isDiv;
    logic             divZero, divOvf, special, start, step;
    logic [XLEN-1:0]  op1x, op2x, mostNeg, specRaw, specVal, dpResult;
    logic [CNT_W-1:0] nIter;

    assign req_ready  = (state_q == MDU_IDLE);
    assign busy       = (state_q != MDU_IDLE);
    assign resp_valid = respValid_q;
    assign resp_data  = respData_q;

    assign accept = req_valid && req_ready && !flush;
    assign sgn1   = opSigned1(req_op);
    assign sgn2   = opSigned2(req_op);
    assign isDiv  = req_op[2];

    assign op1x = !is_word_opt ? op1 :
                  {{(XLEN-32){sgn1 & op1[31]}}, op1[31:0]};
    assign op2x = !is_word_opt ? op2 :
                  {{(XLEN-32){sgn2 & op2[31]}}, op2[31:0]};
    assign neg1 = sgn1 & op1x[XLEN-1];
    assign neg2 = sgn2 & op2x[XLEN-1];

    // Divide by zero and most-negative / -1 finish without iterating
    assign mostNeg = is_word_opt ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign divZero = isDiv && (op2x == '0);
    assign divOvf  = isDiv && sgn1 && (op1x == mostNeg) && (op2x == '1);
    assign special = divZero || divOvf;
    assign specRaw = opIsRem(req_op) ? (divZero ? op1x : '0) : (divZero ? '1 : op1x);
    assign specVal = is_word_opt ? {{(XLEN-32){specRaw[31]}}, specRaw[31:0]} : specRaw;

    assign nIter = word_q ? CNT_W'(32) : CNT_W'(XLEN);
    assign start = accept && !special;
    assign step  = (state_q == MDU_CALC) && (counter_q != nIter);

    exe_muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .step_i    (step),
        .is_mul_i  (!req_op[2]),
        .is_word_i (is_word_opt),
        .op_i      (req_op),
        .op1_i     (op1x),
        .op2_i     (op2x),
        .neg1_i    (neg1),
        .neg2_i    (neg2),
        .result_o  (dpResult)
    );

    // FSM: counter tracks completed steps; the result is captured one edge after the last step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MDU_IDLE;
            counter_q   <= '0;
            word_q      <= 1'b0;
            respValid_q <= 1'b0;
            respData_q  <= '0;
        end else if (flush) begin
            state_q     <= MDU_IDLE;
            counter_q   <= '0;
            respValid_q <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (req_valid) begin
                        word_q    <= is_word_opt;
                        counter_q <= '0;
                        if (special) begin
                            state_q     <= MDU_DONE;
                            respValid_q <= 1'b1;
                            respData_q  <= specVal;
                        end else begin
                            state_q <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    if (counter_q == nIter) begin
                        state_q     <= MDU_DONE;
                        counter_q   <= '0;
                        respValid_q <= 1'b1;
                        respData_q  <= dpResult;
                    end else begin
                        counter_q <= counter_q + 1'b1;
                    end
                end
                MDU_DONE: begin
                    if (resp_ready) begin
                        state_q     <= MDU_IDLE;
                        respValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= MDU_IDLE;
                    respValid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Self-checking bench for exe_muldiv_ctrl: a table of directed operations with
// hand-computed results and latencies, followed by flush, backpressure and
// asynchronous-reset sequences.
module tb_exe_muldiv_ctrl;
    import exe_muldiv_ctrl_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NEG7 = 64'hFFFF_FFFF_FFFF_FFF9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic        is_word_opt = 1'b0;
    logic [63:0] op1 = '0;
    logic [63:0] op2 = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        busy;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecQ[$];

    always #5 clk = ~clk;

    exe_muldiv_ctrl #(.XLEN(64), .CNT_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .is_word_opt (is_word_opt),
        .op1         (op1),
        .op2         (op2),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // lat = edges after the accepting edge until resp_valid is seen (0: resolved on that edge)
    task automatic addVec(input logic [2:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        vec_t v;
        v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecQ.push_back(v);
    endtask

    // Offer one operation, let it be accepted, then scramble the inputs
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        checkOutput({name, " req_ready before issue"}, 64'(req_ready), 64'd1);
        req_valid   = 1'b1;
        req_op      = op;
        is_word_opt = word;
        op1         = a;
        op2         = b;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_op      = 3'($urandom());
        is_word_opt = 1'($urandom());
        op1         = {$urandom(), $urandom()};
        op2         = {$urandom(), $urandom()};
    endtask

    // Count edges until resp_valid, checking busy stays high; bounded
    task automatic waitResp(output int edges, output logic busyOk);
        edges  = 0;
        busyOk = 1'b1;
        while (resp_valid !== 1'b1 && edges < 300) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        if (busy !== 1'b1) busyOk = 1'b0;
    endtask

    // Take the result and verify the unit returns to IDLE on that edge
    task automatic consume(input string name);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput({name, " resp_valid after consume"}, 64'(resp_valid), 64'd0);
        checkOutput({name, " req_ready after consume"}, 64'(req_ready), 64'd1);
        checkOutput({name, " busy after consume"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          edges;
        logic        busyOk;
        logic        sawValid;
        logic [63:0] lastData;

        addVec(MDU_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        addVec(MDU_MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        addVec(MDU_MULH,   1'b0, ONES, ONES, 64'd0, 65);
        addVec(MDU_MULHSU, 1'b0, ONES, 64'd2, ONES, 65);
        addVec(MDU_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        addVec(MDU_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
        addVec(MDU_REM,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 0);
        addVec(MDU_DIVU,   1'b0, 64'd123, 64'd0, ONES, 0);
        addVec(MDU_REM,    1'b0, NEG7, 64'd0, NEG7, 0);
        addVec(MDU_REMU,   1'b1, 64'hFFFF_FFFF_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 0);
        addVec(MDU_DIV,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 0);
        addVec(MDU_REM,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 0);
        addVec(MDU_REM,    1'b0, NEG7, 64'd2, ONES, 65);
        addVec(MDU_DIV,    1'b0, NEG7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        addVec(MDU_DIVU,   1'b1, 64'd100, 64'd7, 64'd14, 33);
        addVec(MDU_DIVU,   1'b0, ONES, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        addVec(MDU_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65);
        addVec(MDU_DIV,    1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33);
        addVec(MDU_REM,    1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33);

        // Power-on reset
        #2 rst = 1'b0;
        #1;
        checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset resp_data", resp_data, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset req_ready after release", 64'(req_ready), 64'd1);

        // Table of directed operations
        foreach (vecQ[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            applyStimulus(nm, vecQ[i].op, vecQ[i].word, vecQ[i].a, vecQ[i].b);
            waitResp(edges, busyOk);
            checkOutput({nm, " latency"}, 64'(edges), 64'(vecQ[i].lat));
            checkOutput({nm, " resp_data"}, resp_data, vecQ[i].exp);
            checkOutput({nm, " busy held"}, 64'(busyOk), 64'd1);
            consume(nm);
        end
        lastData = 64'hFFFF_FFFF_FFFF_FFFE;

        // Flush in CALC together with a new request: flush wins, nothing accepted
        applyStimulus("flushCalc", MDU_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (19) @(posedge clk);
        @(negedge clk);
        checkOutput("flushCalc busy before flush", 64'(busy), 64'd1);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = MDU_MUL;
        op1       = 64'd5;
        op2       = 64'd5;
        @(posedge clk);
        #1;
        checkOutput("flushCalc busy", 64'(busy), 64'd0);
        checkOutput("flushCalc resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("flushCalc req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("flushCalc nothing accepted", 64'(busy), 64'd0);
        sawValid = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) sawValid = 1'b1;
        end
        checkOutput("flushCalc resp_valid never", 64'(sawValid), 64'd0);
        checkOutput("flushCalc resp_data kept", resp_data, lastData);

        // Flush together with resp_ready in DONE: result discarded, back to IDLE
        applyStimulus("flushDone", MDU_REM, 1'b0, NEG7, 64'd0);
        checkOutput("flushDone resp_valid", 64'(resp_valid), 64'd1);
        @(negedge clk);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        resp_ready = 1'b0;
        checkOutput("flushDone resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("flushDone busy", 64'(busy), 64'd0);
        checkOutput("flushDone resp_data kept", resp_data, NEG7);

        // Backpressure: result held stable for 10 cycles
        applyStimulus("backpressure", MDU_DIVU, 1'b1, 64'd100, 64'd7);
        waitResp(edges, busyOk);
        checkOutput("backpressure latency", 64'(edges), 64'd33);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("backpressure c%0d resp_valid", c), 64'(resp_valid), 64'd1);
            checkOutput($sformatf("backpressure c%0d resp_data", c), resp_data, 64'd14);
            checkOutput($sformatf("backpressure c%0d req_ready", c), 64'(req_ready), 64'd0);
        end
        consume("backpressure");

        // Asynchronous reset in the middle of CALC
        applyStimulus("midReset", MDU_DIV, 1'b0, NEG7, 64'd2);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midReset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("midReset resp_data", resp_data, 64'd0);
        checkOutput("midReset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset req_ready after release", 64'(req_ready), 64'd1);
        checkOutput("midReset no stale result", 64'(resp_valid), 64'd0);

        // Unit still works after the reset
        applyStimulus("afterReset", MDU_DIVU, 1'b1, 64'd100, 64'd7);
        waitResp(edges, busyOk);
        checkOutput("afterReset latency", 64'(edges), 64'd33);
        checkOutput("afterReset resp_data", resp_data, 64'd14);
        consume("afterReset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
